// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: startup flush, freeze,
// redirect and load-use handling, saturating perf counters and a hang detector.
module pipeline_hazard_ctrl #(
    parameter int unsigned STARTUP_CYCLES = 3,
    parameter int unsigned COUNT_W        = 32,
    parameter int unsigned FREEZE_TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               imem_busywait,
    input  logic               dmem_busywait,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic               ex_valid,
    input  logic               ex_memRead,
    input  logic [4:0]         ex_des_register,
    input  logic               ex_branch_taken,
    input  logic               ex_jump,
    input  logic               clear_counters,
    output logic               pc_write,
    output logic               pc_redirect,
    output logic               pipe_busywait,
    output logic               hold_if_id,
    output logic               flush_if_id,
    output logic               flush_id_ex,
    output logic               flush_ex_mem,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count,
    output logic               hang_error
);

    localparam int unsigned FRZ_W = $clog2(FREEZE_TIMEOUT + 1);

    typedef enum logic {STARTUP, RUN} state_t;

    state_t             state;
    logic [3:0]         startup_cnt;
    logic [FRZ_W-1:0]   freeze_cnt;

    logic freeze;
    logic redirect;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign freeze   = imem_busywait | dmem_busywait;
    assign redirect = ex_valid & (ex_branch_taken | ex_jump);
    assign load_use = ex_valid & ex_memRead & (ex_des_register != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_des_register)) |
                       (id_rs2_used & (id_rs2 == ex_des_register)));

    assign stall_inc = (state == RUN) & (freeze | (~redirect & load_use));
    assign flush_inc = (state == RUN) & ~freeze & redirect;

    // Reset is folded in so the flush outputs are already active in the reset cycle.
    always_comb begin
        pc_write      = 1'b0;
        pc_redirect   = 1'b0;
        pipe_busywait = 1'b0;
        hold_if_id    = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        if (reset || state == STARTUP) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (freeze) begin
            pipe_busywait = 1'b1;
        end else if (redirect) begin
            pc_write    = 1'b1;
            pc_redirect = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= STARTUP;
            startup_cnt <= 4'(STARTUP_CYCLES - 1);
            freeze_cnt  <= '0;
            stall_count <= '0;
            flush_count <= '0;
            hang_error  <= 1'b0;
        end else begin
            case (state)
                STARTUP: begin
                    freeze_cnt <= '0;
                    if (startup_cnt == 4'd0)
                        state <= RUN;
                    else
                        startup_cnt <= startup_cnt - 4'd1;
                end
                RUN: begin
                    if (freeze) begin
                        if (freeze_cnt != FRZ_W'(FREEZE_TIMEOUT))
                            freeze_cnt <= freeze_cnt + 1'b1;
                        // Set on the edge that completes the FREEZE_TIMEOUT-th freeze cycle.
                        if (freeze_cnt >= FRZ_W'(FREEZE_TIMEOUT - 1))
                            hang_error <= 1'b1;
                    end else begin
                        freeze_cnt <= '0;
                    end
                end
                default: state <= STARTUP;
            endcase

            if (clear_counters) begin
                stall_count <= '0;
                flush_count <= '0;
            end else begin
                if (stall_inc && stall_count != '1)
                    stall_count <= stall_count + 1'b1;
                if (flush_inc && flush_count != '1)
                    flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; small COUNT_W and FREEZE_TIMEOUT
// so saturation and hang detection are reachable quickly.
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       imem_busywait, dmem_busywait;
    logic [4:0] id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used;
    logic       ex_valid, ex_memRead;
    logic [4:0] ex_des_register;
    logic       ex_branch_taken, ex_jump, clear_counters;
    logic       pc_write, pc_redirect, pipe_busywait, hold_if_id;
    logic       flush_if_id, flush_id_ex, flush_ex_mem;
    logic [3:0] stall_count, flush_count;
    logic       hang_error;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // {pc_write, pc_redirect, pipe_busywait, hold_if_id, flush_if_id, flush_id_ex, flush_ex_mem}
    logic [6:0] outs;
    assign outs = {pc_write, pc_redirect, pipe_busywait, hold_if_id,
                   flush_if_id, flush_id_ex, flush_ex_mem};

    localparam logic [6:0] O_START = 7'b0000111;
    localparam logic [6:0] O_RUN   = 7'b1000000;
    localparam logic [6:0] O_FRZ   = 7'b0010000;
    localparam logic [6:0] O_RED   = 7'b1100110;
    localparam logic [6:0] O_LU    = 7'b0001010;

    pipeline_hazard_ctrl #(
        .STARTUP_CYCLES(3),
        .COUNT_W(4),
        .FREEZE_TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset),
        .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_memRead(ex_memRead),
        .ex_des_register(ex_des_register),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
        .clear_counters(clear_counters),
        .pc_write(pc_write), .pc_redirect(pc_redirect),
        .pipe_busywait(pipe_busywait), .hold_if_id(hold_if_id),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem),
        .stall_count(stall_count), .flush_count(flush_count),
        .hang_error(hang_error)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        imem_busywait = 0; dmem_busywait = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_valid = 0; ex_memRead = 0; ex_des_register = 0;
        ex_branch_taken = 0; ex_jump = 0; clear_counters = 0;
    endtask

    // Entered and left just after a falling edge; comb outputs sampled #1 later.
    task automatic reset_to_run();
        idle_inputs();
        reset = 1;
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        repeat (3) @(negedge clock);
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_valid = 1; ex_memRead = 1; ex_des_register = rd;
        id_rs2 = rd; id_rs2_used = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (outs !== O_START) begin
                n_err++;
                $display("FAIL reset_outs cyc%0d got %b want %b", i, outs, O_START);
            end
            @(negedge clock);
        end
        reset = 0;
        imem_busywait = 1;  // must be ignored while starting up
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (outs !== O_START) begin
                n_err++;
                $display("FAIL startup_outs cyc%0d got %b want %b", i, outs, O_START);
            end
            @(negedge clock);
        end
        imem_busywait = 0;
        #1;
        n_vec++;
        if (outs !== O_RUN) begin
            n_err++;
            $display("FAIL run_begins got %b want %b", outs, O_RUN);
        end
        n_vec++;
        if ({stall_count, flush_count, hang_error} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_counters got stall=%0d flush=%0d hang=%b want 0 0 0",
                     stall_count, flush_count, hang_error);
        end
        @(negedge clock);
    endtask

    task automatic test_load_use();
        reset_to_run();
        set_load_use(5'd5);
        #1;
        n_vec++;
        if (outs !== O_LU) begin
            n_err++;
            $display("FAIL load_use_outs got %b want %b", outs, O_LU);
        end
        @(negedge clock);
        ex_valid = 0;  // the bubble reached EX
        #1;
        n_vec++;
        if (outs !== O_RUN || stall_count !== 4'd1) begin
            n_err++;
            $display("FAIL load_use_after got %b stall=%0d want %b stall=1", outs, stall_count, O_RUN);
        end
        @(negedge clock);
        set_load_use(5'd0);
        #1;
        n_vec++;
        if (outs !== O_RUN) begin
            n_err++;
            $display("FAIL x0_no_stall got %b want %b", outs, O_RUN);
        end
        @(negedge clock);
        // rs1 matches but is not read -> no stall
        set_load_use(5'd7);
        id_rs2 = 5'd3; id_rs1 = 5'd7; id_rs1_used = 0;
        #1;
        n_vec++;
        if (outs !== O_RUN) begin
            n_err++;
            $display("FAIL rs1_unused got %b want %b", outs, O_RUN);
        end
        id_rs1_used = 1;
        #1;
        n_vec++;
        if (outs !== O_LU) begin
            n_err++;
            $display("FAIL rs1_match got %b want %b", outs, O_LU);
        end
        @(negedge clock);
        idle_inputs();
        #1;
        n_vec++;
        if (stall_count !== 4'd2) begin
            n_err++;
            $display("FAIL load_use_count got %0d want 2", stall_count);
        end
    endtask

    task automatic test_redirect_priority();
        reset_to_run();
        set_load_use(5'd9);
        ex_branch_taken = 1;
        #1;
        n_vec++;
        if (outs !== O_RED) begin
            n_err++;
            $display("FAIL redirect_over_lu got %b want %b", outs, O_RED);
        end
        @(negedge clock);
        idle_inputs();
        ex_branch_taken = 1;  // not a real instruction in EX
        #1;
        n_vec++;
        if (outs !== O_RUN || flush_count !== 4'd1 || stall_count !== 4'd0) begin
            n_err++;
            $display("FAIL redirect_counts got %b flush=%0d stall=%0d want %b flush=1 stall=0",
                     outs, flush_count, stall_count, O_RUN);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_freeze_jump();
        reset_to_run();
        ex_valid = 1; ex_jump = 1; dmem_busywait = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (outs !== O_FRZ) begin
                n_err++;
                $display("FAIL freeze_outs cyc%0d got %b want %b", i, outs, O_FRZ);
            end
            @(negedge clock);
        end
        dmem_busywait = 0;
        #1;
        n_vec++;
        if (outs !== O_RED) begin
            n_err++;
            $display("FAIL redirect_after_freeze got %b want %b", outs, O_RED);
        end
        @(negedge clock);
        idle_inputs();
        #1;
        n_vec++;
        if (stall_count !== 4'd5 || flush_count !== 4'd1 || hang_error !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_counts got stall=%0d flush=%0d hang=%b want 5 1 0",
                     stall_count, flush_count, hang_error);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp;
        reset_to_run();
        set_load_use(5'd12);
        for (int i = 0; i < 20; i++) begin
            exp = (i < 15) ? 4'(i) : 4'd15;
            #1;
            n_vec++;
            if (stall_count !== exp || outs !== O_LU) begin
                n_err++;
                $display("FAIL sat_stall cyc%0d got %0d/%b want %0d/%b", i, stall_count, outs, exp, O_LU);
            end
            @(negedge clock);
        end
        #1;
        n_vec++;
        if (stall_count !== 4'd15) begin
            n_err++;
            $display("FAIL sat_hold got %0d want 15", stall_count);
        end
        clear_counters = 1;
        @(negedge clock);
        clear_counters = 0;
        #1;
        n_vec++;
        if (stall_count !== 4'd0) begin
            n_err++;
            $display("FAIL clear_over_inc got %0d want 0", stall_count);
        end
        @(negedge clock);
        #1;
        n_vec++;
        if (stall_count !== 4'd1) begin
            n_err++;
            $display("FAIL inc_after_clear got %0d want 1", stall_count);
        end
        idle_inputs();
    endtask

    task automatic test_hang();
        reset_to_run();
        // 7 + break + 7 must not trip the detector
        imem_busywait = 1;
        repeat (7) @(negedge clock);
        imem_busywait = 0;
        @(negedge clock);
        imem_busywait = 1;
        repeat (7) @(negedge clock);
        #1;
        n_vec++;
        if (hang_error !== 1'b0) begin
            n_err++;
            $display("FAIL hang_early got %b want 0", hang_error);
        end
        @(negedge clock);
        #1;
        n_vec++;
        if (hang_error !== 1'b1 || outs !== O_FRZ) begin
            n_err++;
            $display("FAIL hang_set got %b/%b want 1/%b", hang_error, outs, O_FRZ);
        end
        imem_busywait = 0;
        clear_counters = 1;
        @(negedge clock);
        clear_counters = 0;
        #1;
        n_vec++;
        if (hang_error !== 1'b1 || stall_count !== 4'd0 || outs !== O_RUN) begin
            n_err++;
            $display("FAIL hang_sticky got hang=%b stall=%0d outs=%b want 1 0 %b",
                     hang_error, stall_count, outs, O_RUN);
        end
        reset = 1;
        @(negedge clock);
        reset = 0;
        #1;
        n_vec++;
        if (hang_error !== 1'b0) begin
            n_err++;
            $display("FAIL hang_reset got %b want 0", hang_error);
        end
    endtask

    task automatic test_reset_midop();
        reset_to_run();
        dmem_busywait = 1; ex_valid = 1; ex_jump = 1;
        @(negedge clock);
        reset = 1;
        #1;
        n_vec++;
        if (outs !== O_START) begin
            n_err++;
            $display("FAIL reset_in_freeze got %b want %b", outs, O_START);
        end
        @(negedge clock);
        reset = 0;
        dmem_busywait = 0;
        #1;
        n_vec++;
        if (outs !== O_START || stall_count !== 4'd0 || flush_count !== 4'd0) begin
            n_err++;
            $display("FAIL midop_startup got %b stall=%0d flush=%0d want %b 0 0",
                     outs, stall_count, flush_count, O_START);
        end
        repeat (3) @(negedge clock);
        #1;
        n_vec++;
        if (outs !== O_RED) begin
            n_err++;
            $display("FAIL midop_run got %b want %b", outs, O_RED);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(negedge clock);
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_freeze_jump();
        test_saturation();
        test_hang();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
